sseg_scan_capture: RTL and testbench
====================================

// Module: sseg_scan_capture
// PURPOSE
//  Receive-side monitor for the multiplexed 4-digit seven-segment bus (an/seg/dp, all active-low).
//  Samples the bus, waits for each lit digit to settle, and decodes its segment pattern back to a hex nibble.
//  Tracks per-digit freshness and flags bus faults.
//  Sits beside the display driver, for on-board self-check and as a bench scoreboard front end.
// PARAMETERS
//  SETTLE_CYCLES   4        consecutive identical samples required before a digit is captured (>=1)
//  STALE_CYCLES    400000   cycles without recapture before a digit's fresh bit drops (>=SETTLE_CYCLES)
// PORTS
//  clk          in   1   system clock; single clock domain
//  reset        in   1   synchronous, active-high reset
//  an           in   4   anode enables, active-low; an[0] = rightmost digit
//  seg          in   7   segments, active-low; seg[0]=a ... seg[6]=g
//  dp           in   1   decimal point, active-low
//  digit_val    out  16  captured hex; digit i in [4i+3:4i]
//  digit_ok     out  4   1 = last capture of digit i was a legal hex pattern
//  digit_dp     out  4   dp state (1 = lit) at last capture of digit i
//  digit_fresh  out  4   1 = digit i captured within the last STALE_CYCLES
//  frame_valid  out  1   one-cycle pulse when all 4 digits captured since previous pulse
//  bus_err      out  1   sticky: >1 anode active simultaneously; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; sample registers loaded with an=4'hF, seg=7'h7F; counters 0.
//  - Inputs are registered once (1-cycle input stage) before any decision.
//  - onehot_low = exactly one bit of registered an is 0. multi = two or more bits are 0.
//  - FSM states:
//    - IDLE: no anode active. On onehot_low, go to SETTLE, latch {an,seg,dp}, cnt=1.
//    - SETTLE:
//      - Sample equals latch: cnt++. When cnt==SETTLE_CYCLES, go to CAPTURE.
//      - Sample differs but still onehot_low: relatch, cnt=1, stay.
//      - No anode active: go to IDLE.
//    - CAPTURE: 1 cycle. Write digit_val/ok/dp for the latched index. Mark captured[i]; reload stale[i]. Go to HOLD.
//    - HOLD: wait until an changes (any bit), then IDLE or SETTLE per rules above. A digit is captured once per lit period.
//  - multi in any state: set bus_err, go to IDLE, no capture this cycle.
//  - Latency: last stable input edge -> digit_val update = 1 (input reg) + SETTLE_CYCLES + 1 cycles.
//  - Decode uses 16 legal patterns (hex 0-9, A, b, C, d, E, F; active-high form in package).
//  - Illegal pattern (incl. blank): digit_ok[i]=0, digit_val nibble = 4'h0, digit_dp still updated.
//  - Freshness: stale[i] reloads to STALE_CYCLES on capture, else decrements and saturates at 0.
//    digit_fresh[i] = (stale[i] != 0).
//  - Frame: captured[3:0] accumulates. When all ones, in the same cycle: frame_valid pulses and captured clears.
//    A capture in the clear cycle is kept (set wins over clear for that bit).
//  - Reset asserted mid-SETTLE/CAPTURE: capture aborted, outputs cleared next edge.
// STRUCTURE
//  - Package sseg_pkg: typedef state_t {IDLE,SETTLE,CAPTURE,HOLD}; SEG_HEX[16] active-high pattern table;
//    ANODE_IDLE=4'hF; function onehot_idx().
//  - Sub-module sseg_pattern_decode: combinational seg[6:0] (active-high) -> {ok, nibble[3:0]}; used once.
//  - Top holds: input regs, FSM, settle counter, 4 stale counters, captured mask.
// TESTING
//  1 Reset: hold reset 3 cycles with an=4'h0 -> all outputs 0, bus_err stays 0 after release until bus driven.
//  2 an=4'b1110, seg=7'b0100100 ("2", active-low) for 8 cycles -> digit_val[3:0]=2, ok[0]=1,
//    update exactly SETTLE_CYCLES+2 cycles after edge.
//  3 Scan 4 digits "1,2,3,4" for 6 cycles each, repeat -> digit_val=16'h4321,
//    frame_valid single pulse per full scan.
//  4 Glitch: seg changes at cycle 2 of settle -> no capture until 4 fresh stable cycles.
//    seg=7'h7F (blank) -> ok=0, val nibble 0.
//  5 an=4'b1100 for 1 cycle -> bus_err=1 sticky, no digit written; stays 1 through valid scans until reset.
//  6 STALE_CYCLES=20: stop driving digit 3 (an=4'hF) -> digit_fresh[3] falls exactly 20 cycles
//    after its last capture, others unaffected.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types, segment pattern table and anode helpers for the seven-segment bus monitor.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [3:0] ANODE_IDLE = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  // Active-high segment patterns, bit0 = a ... bit6 = g, indexed by hex value.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Index of the active (low) anode; only meaningful when exactly one is low.
  function automatic logic [1:0] onehot_idx(input logic [3:0] an);
    onehot_idx = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!an[i]) onehot_idx = i[1:0];
    end
  endfunction

endpackage

// File: rtl/sseg_scan_capture_if.sv
// Multiplexed seven-segment display bus (all signals active-low).
interface sseg_scan_capture_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output an, seg, dp);
  modport slave  (input  an, seg, dp);
endinterface

// File: rtl/sseg_pattern_decode.sv
// Maps an active-high segment pattern back to its hex nibble; unknown patterns give ok=0, nibble=0.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] nibble
);

  always_comb begin
    ok     = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        ok     = 1'b1;
        nibble = i[3:0];
      end
    end
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment bus: settles, captures and
// decodes each lit digit, tracks per-digit freshness and frame completion, flags multi-anode faults.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 400000
) (
  input  logic                   clk,
  input  logic                   reset,
  sseg_scan_capture_if.slave     bus,
  output logic [15:0]            digit_val,
  output logic [3:0]             digit_ok,
  output logic [3:0]             digit_dp,
  output logic [3:0]             digit_fresh,
  output logic                   frame_valid,
  output logic                   bus_err
);

  localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SW = (STALE_CYCLES  < 2) ? 1 : $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] STALE_LOAD = SW'(STALE_CYCLES);
  localparam bit            INSTANT    = (SETTLE_CYCLES <= 1);

  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    lat_an;
  logic [6:0]    lat_seg;
  logic          lat_dp;

  logic [SW-1:0] stale [4];
  logic [3:0]    captured;

  logic [3:0]    act, act_m1;
  logic          multi, onehot, same;
  logic          latch, err_set, cap;
  logic [1:0]    cap_idx;
  logic          dec_ok;
  logic [3:0]    dec_nib;

  assign act    = ~an_r;
  assign act_m1 = act - 4'd1;
  assign multi  = |(act & act_m1);
  assign onehot = (act != '0) && !multi;
  assign same   = (an_r == lat_an) && (seg_r == lat_seg) && (dp_r == lat_dp);

  assign cap_idx = onehot_idx(lat_an);

  sseg_pattern_decode u_decode (
    .seg    (~lat_seg),
    .ok     (dec_ok),
    .nibble (dec_nib)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    err_set = 1'b0;
    cap     = 1'b0;
    if (multi) begin
      state_n = IDLE;
      err_set = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (onehot) begin
            latch   = 1'b1;
            cnt_n   = CW'(1);
            state_n = INSTANT ? CAPTURE : SETTLE;
          end
        end
        SETTLE: begin
          if (!onehot) begin
            state_n = IDLE;
          end else if (same) begin
            cnt_n = cnt + CW'(1);
            if (cnt == CNT_LAST) state_n = CAPTURE;
          end else begin
            latch   = 1'b1;
            cnt_n   = CW'(1);
            state_n = INSTANT ? CAPTURE : SETTLE;
          end
        end
        CAPTURE: begin
          cap     = 1'b1;
          state_n = HOLD;
        end
        HOLD: begin
          // Only an anode change ends the lit period; segment changes under the same anode are ignored.
          if (an_r != lat_an) begin
            if (onehot) begin
              latch   = 1'b1;
              cnt_n   = CW'(1);
              state_n = INSTANT ? CAPTURE : SETTLE;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_r      <= ANODE_IDLE;
      seg_r     <= SEG_BLANK;
      dp_r      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      lat_an    <= ANODE_IDLE;
      lat_seg   <= SEG_BLANK;
      lat_dp    <= 1'b1;
      digit_val <= '0;
      digit_ok  <= '0;
      digit_dp  <= '0;
      captured  <= '0;
      bus_err   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) stale[i] <= '0;
    end else begin
      an_r  <= bus.an;
      seg_r <= bus.seg;
      dp_r  <= bus.dp;
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        lat_an  <= an_r;
        lat_seg <= seg_r;
        lat_dp  <= dp_r;
      end
      if (err_set) bus_err <= 1'b1;
      // Completed frame clears the mask, but a capture landing in that same cycle survives.
      captured <= (frame_valid ? 4'h0 : captured)
                | ((cap ? 4'b0001 : 4'b0000) << cap_idx);
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap && (cap_idx == i[1:0])) begin
          digit_val[4*i +: 4] <= dec_nib;
          digit_ok[i]         <= dec_ok;
          digit_dp[i]         <= ~lat_dp;
          stale[i]            <= STALE_LOAD;
        end else if (stale[i] != '0) begin
          stale[i] <= stale[i] - SW'(1);
        end
      end
    end
  end

  assign frame_valid = (captured == 4'hF);

  always_comb begin
    digit_fresh = '0;
    for (int unsigned i = 0; i < 4; i++) digit_fresh[i] = (stale[i] != '0);
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: vector table plus hand-written latency, glitch, fault and staleness sequences.
module tb_sseg_scan_capture;

  logic        clk;
  logic        reset;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok;
  logic [3:0]  digit_dp;
  logic [3:0]  digit_fresh;
  logic        frame_valid;
  logic        bus_err;

  sseg_scan_capture_if bus ();

  sseg_scan_capture #(
    .SETTLE_CYCLES (4),
    .STALE_CYCLES  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .digit_val   (digit_val),
    .digit_ok    (digit_ok),
    .digit_dp    (digit_dp),
    .digit_fresh (digit_fresh),
    .frame_valid (frame_valid),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic mon_en = 1'b0;
  int   fv_cnt = 0;
  int   fv_run = 0;
  int   fv_maxrun = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_valid) begin
        fv_cnt = fv_cnt + 1;
        fv_run = fv_run + 1;
        if (fv_run > fv_maxrun) fv_maxrun = fv_run;
      end else begin
        fv_run = 0;
      end
    end
  end

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] cyc;
    logic [15:0] val;
    logic [3:0]  ok;
    logic [3:0]  dpx;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int unsigned n);
    bus.an  = a;
    bus.seg = s;
    bus.dp  = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int unsigned n);
    drive(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [6:0] scan_seg [4];
  logic [3:0] a;
  logic [3:0] exp_fresh;

  initial begin
    // Expected values accumulate across the table: val / ok / dp after each vector.
    tbl[0] = '{4'b1101, 7'b0001000, 1'b0, 32'd8, 16'h00A2, 4'b0011, 4'b0010}; // A, dp lit
    tbl[1] = '{4'b1011, 7'b0000011, 1'b1, 32'd8, 16'h0BA2, 4'b0111, 4'b0010}; // b
    tbl[2] = '{4'b0111, 7'b0001110, 1'b0, 32'd8, 16'hFBA2, 4'b1111, 4'b1010}; // F, dp lit
    tbl[3] = '{4'b1110, 7'b1111111, 1'b0, 32'd8, 16'hFBA0, 4'b1110, 4'b1011}; // blank
    tbl[4] = '{4'b0111, 7'b1111000, 1'b1, 32'd4, 16'h7BA0, 4'b1110, 4'b0011}; // 7, minimum lit time
    tbl[5] = '{4'b1011, 7'b0000000, 1'b0, 32'd3, 16'h7BA0, 4'b1110, 4'b0011}; // 8, too short
    tbl[6] = '{4'b1110, 7'b1111110, 1'b1, 32'd8, 16'h7BA0, 4'b1110, 4'b0010}; // 'a' only, illegal
    tbl[7] = '{4'b1101, 7'b0010000, 1'b1, 32'd8, 16'h7B90, 4'b1110, 4'b0000}; // 9
    tbl[8] = '{4'b1110, 7'b0010010, 1'b1, 32'd6, 16'h7B95, 4'b1111, 4'b0000}; // 5
    scan_seg[0] = 7'b1111001;
    scan_seg[1] = 7'b0100100;
    scan_seg[2] = 7'b0110000;
    scan_seg[3] = 7'b0011001;

    // Reset with all anodes driven low
    reset   = 1'b1;
    bus.an  = 4'h0;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_val",   {16'h0, digit_val}, 32'h0);
    check("rst_ok",    {28'h0, digit_ok}, 32'h0);
    check("rst_dp",    {28'h0, digit_dp}, 32'h0);
    check("rst_fresh", {28'h0, digit_fresh}, 32'h0);
    check("rst_frame", {31'h0, frame_valid}, 32'h0);
    check("rst_err",   {31'h0, bus_err}, 32'h0);
    bus.an = 4'hF;
    reset  = 1'b0;
    blank(3);
    check("post_rst_err", {31'h0, bus_err}, 32'h0);
    check("post_rst_val", {16'h0, digit_val}, 32'h0);

    // Single digit "2": update lands exactly SETTLE_CYCLES+2 edges after the input change
    bus.an  = 4'b1110;
    bus.seg = 7'b0100100;
    bus.dp  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_val_k%0d", k), {28'h0, digit_val[3:0]}, (k >= 6) ? 32'h2 : 32'h0);
      check($sformatf("lat_ok_k%0d", k), {31'h0, digit_ok[0]}, (k >= 6) ? 32'h1 : 32'h0);
    end
    blank(3);
    check("lat_dp", {28'h0, digit_dp}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].cyc);
      blank(3);
      check($sformatf("vec%0d_val", i), {16'h0, digit_val}, {16'h0, tbl[i].val});
      check($sformatf("vec%0d_ok", i), {28'h0, digit_ok}, {28'h0, tbl[i].ok});
      check($sformatf("vec%0d_dp", i), {28'h0, digit_dp}, {28'h0, tbl[i].dpx});
    end
    check("vec_err", {31'h0, bus_err}, 32'h0);

    // Two full scans of 1,2,3,4: one single-cycle frame pulse per scan
    do_reset();
    mon_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        a = ~(4'b0001 << d);
        drive(a, scan_seg[d], 1'b1, 6);
      end
    end
    blank(6);
    mon_en = 1'b0;
    check("scan_val", {16'h0, digit_val}, 32'h4321);
    check("scan_ok", {28'h0, digit_ok}, 32'hF);
    check("frame_pulses", fv_cnt, 32'd2);
    check("frame_width", fv_maxrun, 32'd1);

    // Glitch: "6" for 2 cycles then "8"; capture only after the 8 has settled fully
    drive(4'b1110, 7'b0000010, 1'b1, 2);
    bus.seg = 7'b0000000;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("glitch_val_k%0d", k), {28'h0, digit_val[3:0]}, (k >= 6) ? 32'h8 : 32'h1);
    end
    blank(3);
    drive(4'b1110, 7'h7F, 1'b1, 8);
    blank(3);
    check("blank_val", {16'h0, digit_val}, 32'h4320);
    check("blank_ok", {28'h0, digit_ok}, 32'hE);

    // Two anodes for one cycle: sticky bus error, nothing written
    drive(4'b1100, 7'b0100100, 1'b1, 1);
    blank(3);
    check("multi_err", {31'h0, bus_err}, 32'h1);
    check("multi_val", {16'h0, digit_val}, 32'h4320);
    check("multi_ok", {28'h0, digit_ok}, 32'hE);
    drive(4'b1110, 7'b0110000, 1'b1, 8);
    blank(3);
    check("err_sticky", {31'h0, bus_err}, 32'h1);
    check("err_scan_val", {16'h0, digit_val}, 32'h4323);
    do_reset();
    blank(2);
    check("err_cleared", {31'h0, bus_err}, 32'h0);
    check("err_rst_val", {16'h0, digit_val}, 32'h0);

    // Staleness: digit 3 "E" captured once, then only digit 0 "0" is driven
    bus.an  = 4'b0111;
    bus.seg = 7'b0000110;
    bus.dp  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      exp_fresh = {(k >= 6 && k <= 25), 1'b0, 1'b0, (k >= 12)};
      check($sformatf("fresh_k%0d", k), {28'h0, digit_fresh}, {28'h0, exp_fresh});
      if (k == 6) begin
        bus.an  = 4'b1110;
        bus.seg = 7'b1000000;
      end
    end
    check("stale_val", {16'h0, digit_val}, 32'hE000);
    check("stale_ok", {28'h0, digit_ok}, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
